// File: rtl/cmp_pkg.sv
// Shared encodings for the comparator family: FSM state codes and the
// {a_grt, b_grt, a_eq_b} verdict vector.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] VERDICT_NONE  = 3'b000;
    localparam logic [2:0] VERDICT_A_GRT = 3'b100;
    localparam logic [2:0] VERDICT_B_GRT = 3'b010;
    localparam logic [2:0] VERDICT_EQ    = 3'b001;

    function automatic logic [2:0] verdict_of(input logic a_grt, input logic b_grt,
                                              input logic a_eq_b);
        return {a_grt, b_grt, a_eq_b};
    endfunction

endpackage

// File: rtl/comparator.sv
// 2-bit unsigned combinational magnitude comparator.
module comparator (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       a_grt,
    output logic       b_grt,
    output logic       a_eq_b
);

    assign a_grt  = (a > b);
    assign b_grt  = (a < b);
    assign a_eq_b = (a == b);

endmodule

// File: rtl/serial_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator: scans 2-bit digits MSB first through
// one small comparator and folds the results into a registered verdict.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             a_grt,
    output logic             b_grt,
    output logic             a_eq_b
);

    localparam int unsigned DIGITS = WIDTH / 2;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx;
    logic [2:0]       verdict;
    logic             sticky;
    logic             dir_a;

    logic [1:0] a_dig;
    logic [1:0] b_dig;
    logic       dig_a_grt;
    logic       dig_b_grt;
    logic       dig_eq;
    logic [2:0] final_verdict;
    logic       last_digit;

    assign a_dig = a_reg[{idx, 1'b0} +: 2];
    assign b_dig = b_reg[{idx, 1'b0} +: 2];

    comparator u_digit_cmp (
        .a      (a_dig),
        .b      (b_dig),
        .a_grt  (dig_a_grt),
        .b_grt  (dig_b_grt),
        .a_eq_b (dig_eq)
    );

    // A recorded earlier difference overrides the current digit; otherwise the
    // current digit decides (including the all-equal case at idx 0).
    always_comb begin
        final_verdict = verdict_of(dig_a_grt, dig_b_grt, dig_eq);
        if (sticky) begin
            final_verdict = dir_a ? VERDICT_A_GRT : VERDICT_B_GRT;
        end
        last_digit = (idx == '0);
        if (EARLY_EXIT) begin
            last_digit = last_digit || !dig_eq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            idx     <= '0;
            verdict <= VERDICT_NONE;
            sticky  <= 1'b0;
            dir_a   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        a_reg   <= a_in;
                        b_reg   <= b_in;
                        idx     <= IDX_LAST;
                        verdict <= VERDICT_NONE;
                        sticky  <= 1'b0;
                        dir_a   <= 1'b0;
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last_digit) begin
                        verdict <= final_verdict;
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        idx <= idx - IDX_W'(1);
                        if (!sticky && !dig_eq) begin
                            sticky <= 1'b1;
                            dir_a  <= dig_a_grt;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign a_grt  = verdict[2];
    assign b_grt  = verdict[1];
    assign a_eq_b = verdict[0];

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench: one early-exit and one full-scan instance, a vector table plus
// hand-written sequences for hold, ignored start, back-to-back and async reset.
module tb_serial_mag_comparator;

    logic       clk;
    logic       rst_n;
    logic       start_ee;
    logic       start_fs;
    logic [7:0] a_in;
    logic [7:0] b_in;

    logic busy_ee, done_ee, agrt_ee, bgrt_ee, eq_ee;
    logic busy_fs, done_fs, agrt_fs, bgrt_fs, eq_fs;

    int checks = 0;
    int errors = 0;

    serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_ee),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy_ee),
        .done   (done_ee),
        .a_grt  (agrt_ee),
        .b_grt  (bgrt_ee),
        .a_eq_b (eq_ee)
    );

    serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut_fs (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_fs),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy_fs),
        .done   (done_fs),
        .a_grt  (agrt_fs),
        .b_grt  (bgrt_fs),
        .a_eq_b (eq_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         ee;
        logic [7:0] a;
        logic [7:0] b;
        int         lat;
        logic [2:0] verdict;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample(input bit ee, output logic busy, output logic done,
                          output logic [2:0] v);
        if (ee) begin
            busy = busy_ee;
            done = done_ee;
            v    = {agrt_ee, bgrt_ee, eq_ee};
        end else begin
            busy = busy_fs;
            done = done_fs;
            v    = {agrt_fs, bgrt_fs, eq_fs};
        end
    endtask

    // Observation m=1 is the cycle right after the accepting edge; done expected at m=lat.
    task automatic run_cmp(input string name, input bit ee, input logic [7:0] a,
                           input logic [7:0] b, input int lat, input logic [2:0] exp_v);
        logic busy, done;
        logic [2:0] v;
        a_in = a;
        b_in = b;
        if (ee) start_ee = 1'b1;
        else start_fs = 1'b1;
        for (int m = 1; m <= lat; m++) begin
            tick();
            if (m == 1) begin
                start_ee = 1'b0;
                start_fs = 1'b0;
            end
            sample(ee, busy, done, v);
            check({name, " busy"}, 32'(busy), 32'(m < lat));
            check({name, " done"}, 32'(done), 32'(m == lat));
            check({name, " verdict"}, 32'(v), (m == lat) ? 32'(exp_v) : 32'd0);
        end
    endtask

    initial begin
        logic busy, done;
        logic [2:0] v;

        vecs[0]  = '{1'b1, 8'hA5, 8'hA5, 5, 3'b001};
        vecs[1]  = '{1'b1, 8'hC0, 8'h80, 2, 3'b100};
        vecs[2]  = '{1'b1, 8'h12, 8'h13, 5, 3'b010};
        vecs[3]  = '{1'b1, 8'h40, 8'h80, 2, 3'b010};
        vecs[4]  = '{1'b1, 8'h00, 8'h00, 5, 3'b001};
        vecs[5]  = '{1'b1, 8'hFF, 8'hFE, 5, 3'b100};
        vecs[6]  = '{1'b1, 8'h37, 8'h34, 5, 3'b100};
        vecs[7]  = '{1'b1, 8'h1C, 8'h18, 4, 3'b100};
        vecs[8]  = '{1'b0, 8'hC0, 8'h80, 5, 3'b100};
        vecs[9]  = '{1'b0, 8'h12, 8'h13, 5, 3'b010};
        vecs[10] = '{1'b0, 8'hA5, 8'hA5, 5, 3'b001};
        vecs[11] = '{1'b0, 8'h1C, 8'h18, 5, 3'b100};
        vecs[12] = '{1'b0, 8'h80, 8'hC0, 5, 3'b010};

        rst_n    = 1'b0;
        start_ee = 1'b0;
        start_fs = 1'b0;
        a_in     = 8'h00;
        b_in     = 8'h00;
        #3;
        check("reset ee outputs", 32'({busy_ee, done_ee, agrt_ee, bgrt_ee, eq_ee}), 32'd0);
        check("reset fs outputs", 32'({busy_fs, done_fs, agrt_fs, bgrt_fs, eq_fs}), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_cmp($sformatf("vec%0d", i), vecs[i].ee, vecs[i].a, vecs[i].b,
                    vecs[i].lat, vecs[i].verdict);
            tick();
        end

        // Verdict held after an early exit while idle.
        run_cmp("hold", 1'b1, 8'hC0, 8'h80, 2, 3'b100);
        for (int i = 0; i < 10; i++) begin
            tick();
            sample(1'b1, busy, done, v);
            check("hold verdict", 32'(v), 32'(3'b100));
            check("hold done", 32'(done), 32'd0);
        end

        // Full scan ignores a start pulse and new operands mid-RUN.
        a_in     = 8'hC0;
        b_in     = 8'h80;
        start_fs = 1'b1;
        for (int m = 1; m <= 5; m++) begin
            tick();
            start_fs = (m == 2);
            if (m == 2) begin
                a_in = 8'h00;
                b_in = 8'hFF;
            end
            sample(1'b0, busy, done, v);
            check("ignore busy", 32'(busy), 32'(m < 5));
            check("ignore done", 32'(done), 32'(m == 5));
            check("ignore verdict", 32'(v), (m == 5) ? 32'(3'b100) : 32'd0);
        end
        start_fs = 1'b0;
        tick();
        sample(1'b0, busy, done, v);
        check("ignore after busy", 32'(busy), 32'd0);
        check("ignore after verdict", 32'(v), 32'(3'b100));

        // Back-to-back: start held high, second compare accepted in the DONE cycle.
        a_in     = 8'h01;
        b_in     = 8'h02;
        start_ee = 1'b1;
        for (int m = 1; m <= 5; m++) begin
            tick();
            sample(1'b1, busy, done, v);
            check("b2b first done", 32'(done), 32'(m == 5));
            check("b2b first verdict", 32'(v), (m == 5) ? 32'(3'b010) : 32'd0);
        end
        a_in = 8'h03;
        b_in = 8'h03;
        tick();
        start_ee = 1'b0;
        sample(1'b1, busy, done, v);
        check("b2b reaccept busy", 32'(busy), 32'd1);
        check("b2b reaccept done", 32'(done), 32'd0);
        check("b2b cleared verdict", 32'(v), 32'd0);
        for (int m = 2; m <= 5; m++) begin
            tick();
            sample(1'b1, busy, done, v);
            check("b2b second done", 32'(done), 32'(m == 5));
            check("b2b second verdict", 32'(v), (m == 5) ? 32'(3'b001) : 32'd0);
        end
        tick();

        // Asynchronous reset in the middle of a scan.
        a_in     = 8'hA5;
        b_in     = 8'hA5;
        start_ee = 1'b1;
        tick();
        start_ee = 1'b0;
        tick();
        check("pre-reset busy", 32'(busy_ee), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs",
              32'({busy_ee, done_ee, agrt_ee, bgrt_ee, eq_ee}), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post-reset no done", 32'({busy_ee, done_ee}), 32'd0);
        end
        run_cmp("after reset", 1'b1, 8'h40, 8'h80, 2, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Multi-cycle magnitude comparator for WIDTH-bit unsigned operands.
- Sits directly above the team's 2-bit combinational `comparator`. It loads two operands on a start handshake and presents one 2-bit digit pair per cycle, MSB digit first, to an internal `comparator` instance.
- It accumulates the per-digit a_grt/b_grt/a_eq_b results into a single registered verdict, with a done pulse.
- Lets wide compares reuse the small comparator without a wide combinational tree.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. Digit count is DIGITS = WIDTH/2.
- EARLY_EXIT, 1, 1 = finish at the first unequal digit; 0 = always scan all DIGITS digits, with the first difference sticky.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a compare; sampled on rising clk
- a_in  input  WIDTH  operand A; captured when start is accepted
- b_in  input  WIDTH  operand B; captured when start is accepted
- busy  output  1  high while digits are being scanned (RUN state)
- done  output  1  one-cycle pulse; the verdict is valid from this cycle on
- a_grt  output  1  registered verdict A > B
- b_grt  output  1  registered verdict A < B
- a_eq_b  output  1  registered verdict A == B

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - busy, done, a_grt, b_grt, a_eq_b all 0
  - operand registers and digit index 0
- States:
  - IDLE: start=1 accepts. Capture a_in/b_in, set idx = DIGITS-1, clear the three verdict outputs to 0, go to RUN.
  - RUN: busy=1. The internal comparator sees a_reg[2*idx+1:2*idx] and b_reg[2*idx+1:2*idx].
    - EARLY_EXIT=1:
      - if the digit compares unequal, latch a_grt/b_grt from that digit and go to DONE;
      - else if idx==0, latch a_eq_b=1 and go to DONE;
      - else idx decrements.
    - EARLY_EXIT=0:
      - the first unequal digit sets a sticky flag and records its direction; later digits are ignored;
      - at idx==0, latch the recorded direction, or a_eq_b=1 if no digit differed, then go to DONE.
    - start is ignored in RUN. Operands are not re-captured.
  - DONE: done=1 for exactly this cycle and busy=0. Next state is IDLE. start=1 here is accepted exactly as in IDLE (back-to-back compares allowed).
- Verdict outputs:
  - Held stable from DONE until the next accepted start, which clears them to 0 in the following cycle.
  - Exactly one of a_grt/b_grt/a_eq_b is 1 whenever done=1.
- Latency, with start accepted at edge k:
  - RUN occupies k+1 .. k+n, where n is the number of digits scanned.
  - done is high in cycle k+n+1.
  - Full scan: n = DIGITS. Early exit: n = DIGITS - index_of_first_unequal_digit.
  - Minimum total latency is 2 cycles (MSB digit differs).
  - WIDTH=2: always n=1.
- Index wrap: idx never decrements below 0; RUN always exits at idx==0.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values. No done pulse is emitted and no partial verdict is kept.
- Operand inputs may change freely after acceptance with no effect on the result.

Decomposition:
- Shared package/header cmp_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 is illegal and recovers to IDLE);
  - verdict encoding constants, for reuse by other comparator stages.
- One sub-module: the existing 2-bit `comparator`, instantiated once and driven by the digit mux.
- Everything else (operand registers, idx counter, FSM, verdict registers) stays in serial_mag_comparator.

Test Plan (WIDTH=8):
- EARLY_EXIT=1, a_in=8'hA5, b_in=8'hA5, start pulse at edge k:
  - busy=1 for cycles k+1..k+4;
  - done=1 only at k+5, with a_eq_b=1, a_grt=0, b_grt=0.
- EARLY_EXIT=1, a_in=8'hC0, b_in=8'h80 (MSB digit 11 vs 10):
  - busy only at k+1;
  - done at k+2 with a_grt=1; outputs held at a_grt=1 for 10 further idle cycles.
- EARLY_EXIT=1, a_in=8'h12, b_in=8'h13 (differ in LSB digit):
  - done at k+5 with b_grt=1.
- EARLY_EXIT=0, a_in=8'hC0, b_in=8'h80:
  - done at k+5 (full scan) with a_grt=1;
  - a start pulse plus new operands (8'h00, 8'hFF) at k+2 is ignored.
- Back-to-back compares:
  - start held high with 8'h01/8'h02, then 8'h03/8'h03 presented in the DONE cycle;
  - second compare is accepted, verdict clears to 000 in the next cycle;
  - second done reports a_eq_b=1.
- Reset mid-operation:
  - rst_n driven low asynchronously (between clock edges) at k+2 of an 8'hA5/8'hA5 compare;
  - all outputs drop to 0 immediately and no done pulse follows;
  - after release, a new start with 8'h40/8'h80 gives done at k'+2 with b_grt=1.
